traffic_sequencer: RTL and testbench
====================================

# traffic_sequencer

Light-sequencing state machine for the intersection. It owns the 6-bit phase counter and the main/side lamp outputs. It consumes the single-cycle-qualified `enable` produced by the intersection's enable generator, and it feeds that generator the `counter` and the latched pedestrian request `ped`. It also checks that every `enable` lands on the count expected for the current phase, and falls into a sticky all-red fault state otherwise.

## Interface
- `TICK_DIV`, default 1: clock cycles per counter step. Must be ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  phase-advance request from the enable generator; a combinational function of `counter` and `ped`.
- `ped_req`  in  1  pedestrian button, already synchronised; level or pulse.
- `counter`  out  6  phase counter, registered.
- `ped`  out  1  latched pedestrian request, registered; drives the generator's PED input.
- `main_light`  out  3  bit 2 = red, bit 1 = yellow, bit 0 = green; one-hot.
- `side_light`  out  3  same encoding as `main_light`.
- `walk`  out  1  pedestrian walk lamp.
- `fault`  out  1  sticky sequencing-error flag.

## Operation
- Prescaler: `div_cnt` counts 0..TICK_DIV-1 and wraps. `tick = (div_cnt == TICK_DIV-1)`. With TICK_DIV=1, `tick` is constant 1.
- On `tick`, `counter` increments by 1, except at a phase exit where the exit rule below says otherwise.
- Phase states, with the expected exit count E for each and the outputs (main / side / walk):
  - MG: E=11; main 001, side 100, walk 0.
  - MY: E=13; main 010, side 100, walk 0.
  - AR1: E=15; main 100, side 100, walk 0.
  - SG: E=26; main 100, side 001, walk 0.
  - SY: E=28; main 100, side 010, walk 0.
  - AR2: E=30; main 100, side 100, walk 0.
  - WALK: E=40; main 100, side 100, walk 1.
  - FAULT: no exit; main 100, side 100, walk 0.
- Transition condition: `tick && enable && counter == E`. The next states are:
  - MG→MY, MY→AR1, AR1→SG, SG→SY, SY→AR2; counter increments as normal.
  - AR2: goes to WALK with counter←31 if the registered `ped` is 1. Otherwise goes to MG with counter←0.
  - WALK: goes to MG with counter←0 and `ped`←0.
- Fault conditions: `tick && enable && counter != E`, which is a spurious enable; or `tick && !enable && counter == E`, which is a missed enable. Either one moves the FSM to FAULT at the next edge and sets `fault`←1.
- In FAULT, `counter`, `div_cnt` and `ped` freeze at their values from the detecting cycle. Only `rst_n` exits FAULT.
- Pedestrian latch:
  - `ped`←1 when `ped_req` is 1 in any state except WALK and FAULT.
  - A request seen in WALK is ignored, because it is already being served.
  - Clearing on WALK exit takes priority; nothing sets `ped` in that cycle, since the FSM is in WALK.
- All outputs are decoded from registers only. There is no combinational path from `enable` or `ped_req` to any output.

## Timing
- Reset values, applied immediately on `rst_n` low, including mid-phase or in FAULT:
  - state MG, `counter`=0, `div_cnt`=0;
  - `main_light`=001, `side_light`=100;
  - `walk`=0, `ped`=0, `fault`=0.
- Phase lengths in ticks with TICK_DIV=1:
  - MG 12 (counts 0..11), MY 2, AR1 2, SG 11 (16..26), SY 2, AR2 2 (29..30), WALK 10 (31..40).
  - Full cycle: 31 ticks without a pedestrian request, 41 ticks with one.
- Cycle counts: multiply the tick counts by TICK_DIV.
- `enable` stays high for all TICK_DIV cycles of a matching count. It is acted on only in the `tick` cycle, so it advances the phase exactly once.
- The `ped` value used at the AR2 exit is the registered value, not `ped_req` on the same cycle.
- A `ped_req` that arrives in the AR2-exit cycle is latched but does not divert that exit. It is served at the next AR2 exit.
- `fault` rises one clock after the detecting tick. Lamps go all-red on the same edge.
- Counter width: values never exceed 40 in normal operation. A fault freezes the counter, so 41..63 are unreachable.

## Test plan
- TICK_DIV=1, bench models the enable generator, no `ped_req`: lamps go main 001 for 12 cycles, 010 for 2, then all-red for 2. Then side 001 for 11, 010 for 2, then all-red for 2. Counter goes 30→0; period is 31 cycles; `fault` stays 0.
- `ped_req` pulsed during SG: at count 30 the FSM enters WALK with counter=31 and `walk`=1 for 10 cycles. At count 40 it goes to MG with counter=0 and `ped`=0; that period is 41 cycles.
- `ped_req` asserted exactly in the AR2 count-30 cycle: next state is MG with counter=0 and `ped`=1. `walk` rises only after the following AR2 exit, and counter then goes to 31.
- Missed enable: bench holds `enable`=0 at count 11 in MG. Next edge: `fault`=1, main 100, side 100, counter frozen at 11. These values hold for 20 more cycles despite further `enable` pulses.
- Spurious enable: bench drives `enable`=1 at count 5 in MG. Next edge: `fault`=1 and all-red. Then `rst_n` low gives the reset values immediately, and release resumes normal MG counting.
- TICK_DIV=4: MG lasts 48 clocks, with `enable` high for 4 clocks at count 11 and exactly one transition. Asynchronous reset during WALK immediately gives MG, counter 0, `walk` 0, `ped` 0.

Source files
------------

// File: rtl/traffic_sequencer.sv
// traffic_sequencer
// Light-sequencing FSM for the intersection. Owns the 6-bit phase counter,
// the latched pedestrian request and the lamp outputs. Every enable from the
// external enable generator is checked against the exit count of the current
// phase; any mismatch drops the FSM into a sticky all-red FAULT state.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   phase-advance request (function of counter and ped)
//   ped_req    in   synchronised pedestrian button, level or pulse
//   counter    out  registered phase counter
//   ped        out  registered pedestrian request latch
//   main_light out  {red, yellow, green}, one-hot
//   side_light out  {red, yellow, green}, one-hot
//   walk       out  pedestrian walk lamp
//   fault      out  sticky sequencing-error flag
//   state_o    out  current FSM state, debug visibility
module traffic_sequencer #(
   parameter int TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       ped_req,
   output logic [5:0] counter,
   output logic       ped,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       walk,
   output logic       fault,
   output logic [2:0] state_o
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

   localparam logic [2:0] S_MG    = 3'd0;
   localparam logic [2:0] S_MY    = 3'd1;
   localparam logic [2:0] S_AR1   = 3'd2;
   localparam logic [2:0] S_SG    = 3'd3;
   localparam logic [2:0] S_SY    = 3'd4;
   localparam logic [2:0] S_AR2   = 3'd5;
   localparam logic [2:0] S_WALK  = 3'd6;
   localparam logic [2:0] S_FAULT = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [5:0]    counter_q, counter_d;
   logic [DW-1:0] div_q, div_d;
   logic          ped_q, ped_d;
   logic [5:0]    exit_cnt;
   logic          tick;
   logic          at_exit;

   always_comb begin
      exit_cnt = 6'd63;
      case (state_q)
         S_MG:    exit_cnt = 6'd11;
         S_MY:    exit_cnt = 6'd13;
         S_AR1:   exit_cnt = 6'd15;
         S_SG:    exit_cnt = 6'd26;
         S_SY:    exit_cnt = 6'd28;
         S_AR2:   exit_cnt = 6'd30;
         S_WALK:  exit_cnt = 6'd40;
         default: exit_cnt = 6'd63;
      endcase
   end

   assign tick    = (div_q == DIV_MAX);
   assign at_exit = (counter_q == exit_cnt);

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      div_d     = div_q;
      ped_d     = ped_q;
      if (state_q != S_FAULT) begin
         div_d = tick ? '0 : div_q + 1'b1;
         // A request during WALK is already being served, so it is dropped.
         if (ped_req && (state_q != S_WALK)) begin
            ped_d = 1'b1;
         end
         if (tick) begin
            if (enable != at_exit) begin
               // Spurious or missed enable: freeze everything where it is.
               state_d   = S_FAULT;
               counter_d = counter_q;
               div_d     = div_q;
               ped_d     = ped_q;
            end else if (at_exit) begin
               counter_d = counter_q + 6'd1;
               case (state_q)
                  S_MG:  state_d = S_MY;
                  S_MY:  state_d = S_AR1;
                  S_AR1: state_d = S_SG;
                  S_SG:  state_d = S_SY;
                  S_SY:  state_d = S_AR2;
                  S_AR2: begin
                     // Uses the registered latch, so a same-cycle request
                     // waits for the next AR2 exit.
                     if (ped_q) begin
                        state_d   = S_WALK;
                        counter_d = 6'd31;
                     end else begin
                        state_d   = S_MG;
                        counter_d = 6'd0;
                     end
                  end
                  S_WALK: begin
                     state_d   = S_MG;
                     counter_d = 6'd0;
                     ped_d     = 1'b0;
                  end
                  default: state_d = S_FAULT;
               endcase
            end else begin
               counter_d = counter_q + 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_MG;
         counter_q <= 6'd0;
         div_q     <= '0;
         ped_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         div_q     <= div_d;
         ped_q     <= ped_d;
      end
   end

   // Lamp decode from the state register only.
   always_comb begin
      main_light = 3'b100;
      side_light = 3'b100;
      walk       = 1'b0;
      case (state_q)
         S_MG:    main_light = 3'b001;
         S_MY:    main_light = 3'b010;
         S_SG:    side_light = 3'b001;
         S_SY:    side_light = 3'b010;
         S_WALK:  walk       = 1'b1;
         default: begin
            main_light = 3'b100;
            side_light = 3'b100;
         end
      endcase
   end

   assign counter = counter_q;
   assign ped     = ped_q;
   assign fault   = (state_q == S_FAULT);
   assign state_o = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: two instances (TICK_DIV=1 and TICK_DIV=4),
// each fed by a model of the enable generator. dut1's enable can be flipped
// for one cycle to inject missed or spurious enables.
module tb_traffic_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // dut1: TICK_DIV = 1
   logic       rst1_n = 1'b1;
   logic       flip1 = 1'b0;
   logic       ped_req1 = 1'b0;
   logic       enable1;
   logic [5:0] counter1;
   logic       ped1, walk1, fault1;
   logic [2:0] main1, side1, state1;
   logic [14:0] obs1;

   // dut4: TICK_DIV = 4
   logic       rst4_n = 1'b1;
   logic       ped_req4 = 1'b0;
   logic       enable4;
   logic [5:0] counter4;
   logic       ped4, walk4, fault4;
   logic [2:0] main4, side4, state4;
   logic [14:0] obs4;

   function automatic logic gen_en(input logic [5:0] c);
      case (c)
         6'd11, 6'd13, 6'd15, 6'd26, 6'd28, 6'd30, 6'd40: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Expected {main, side, walk} for a count in normal operation.
   function automatic logic [6:0] lamps(input int c);
      if (c <= 11) return {3'b001, 3'b100, 1'b0};
      if (c <= 13) return {3'b010, 3'b100, 1'b0};
      if (c <= 15) return {3'b100, 3'b100, 1'b0};
      if (c <= 26) return {3'b100, 3'b001, 1'b0};
      if (c <= 28) return {3'b100, 3'b010, 1'b0};
      if (c <= 30) return {3'b100, 3'b100, 1'b0};
      return {3'b100, 3'b100, 1'b1};
   endfunction

   assign enable1 = gen_en(counter1) ^ flip1;
   assign enable4 = gen_en(counter4);
   assign obs1 = {counter1, ped1, main1, side1, walk1, fault1};
   assign obs4 = {counter4, ped4, main4, side4, walk4, fault4};

   traffic_sequencer #(.TICK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .enable(enable1), .ped_req(ped_req1),
      .counter(counter1), .ped(ped1), .main_light(main1), .side_light(side1),
      .walk(walk1), .fault(fault1), .state_o(state1)
   );

   traffic_sequencer #(.TICK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .enable(enable4), .ped_req(ped_req4),
      .counter(counter4), .ped(ped4), .main_light(main4), .side_light(side4),
      .walk(walk4), .fault(fault4), .state_o(state4)
   );

   localparam logic [14:0] RESET_OBS = {6'd0, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst1_n = 1'b0;
      #1;
      checks++;
      if (obs1 !== RESET_OBS) begin
         failures++;
         $display("FAIL reset got=%h exp=%h", obs1, RESET_OBS);
      end
      step();
      step();
      rst1_n = 1'b1;
   endtask

   task automatic test_normal();
      logic [14:0] exp;
      for (int k = 1; k <= 62; k++) begin
         step();
         exp = {6'(k % 31), 1'b0, lamps(k % 31), 1'b0};
         checks++;
         if (obs1 !== exp) begin
            failures++;
            $display("FAIL normal k=%0d got=%h exp=%h", k, obs1, exp);
         end
      end
   endtask

   task automatic test_ped_sg();
      logic [14:0] exp;
      int c;
      for (int k = 1; k <= 41; k++) begin
         ped_req1 = (k == 21);
         step();
         c = (k == 41) ? 0 : k;
         exp = {6'(c), ((k >= 21) && (k <= 40)), lamps(c), 1'b0};
         checks++;
         if (obs1 !== exp) begin
            failures++;
            $display("FAIL ped_sg k=%0d got=%h exp=%h", k, obs1, exp);
         end
      end
      ped_req1 = 1'b0;
   endtask

   task automatic test_ped_ar2();
      logic [14:0] exp;
      int c;
      for (int k = 1; k <= 31; k++) begin
         ped_req1 = (k == 31);
         step();
         c = k % 31;
         exp = {6'(c), (k == 31), lamps(c), 1'b0};
         checks++;
         if (obs1 !== exp) begin
            failures++;
            $display("FAIL ped_ar2 k=%0d got=%h exp=%h", k, obs1, exp);
         end
      end
      ped_req1 = 1'b0;
      for (int k = 1; k <= 41; k++) begin
         step();
         c = (k == 41) ? 0 : k;
         exp = {6'(c), (k <= 40), lamps(c), 1'b0};
         checks++;
         if (obs1 !== exp) begin
            failures++;
            $display("FAIL ped_ar2_walk k=%0d got=%h exp=%h", k, obs1, exp);
         end
      end
   endtask

   task automatic test_missed();
      logic [14:0] exp;
      exp = {6'd11, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1};
      for (int k = 1; k <= 11; k++) step();
      flip1 = 1'b1;
      step();
      flip1 = 1'b0;
      checks++;
      if (obs1 !== exp) begin
         failures++;
         $display("FAIL missed got=%h exp=%h", obs1, exp);
      end
      for (int k = 1; k <= 20; k++) begin
         flip1 = (k % 2 == 1);
         ped_req1 = (k % 3 == 0);
         step();
         checks++;
         if (obs1 !== exp) begin
            failures++;
            $display("FAIL missed_hold k=%0d got=%h exp=%h", k, obs1, exp);
         end
      end
      flip1 = 1'b0;
      ped_req1 = 1'b0;
   endtask

   task automatic test_spurious();
      logic [14:0] exp;
      test_reset();
      for (int k = 1; k <= 5; k++) step();
      flip1 = 1'b1;
      step();
      flip1 = 1'b0;
      exp = {6'd5, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1};
      checks++;
      if (obs1 !== exp) begin
         failures++;
         $display("FAIL spurious got=%h exp=%h", obs1, exp);
      end
      #2;
      rst1_n = 1'b0;
      #1;
      checks++;
      if (obs1 !== RESET_OBS) begin
         failures++;
         $display("FAIL spurious_reset got=%h exp=%h", obs1, RESET_OBS);
      end
      rst1_n = 1'b1;
      for (int k = 1; k <= 3; k++) step();
      exp = {6'd3, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0};
      checks++;
      if (obs1 !== exp) begin
         failures++;
         $display("FAIL spurious_resume got=%h exp=%h", obs1, exp);
      end
   endtask

   task automatic test_div4();
      logic [14:0] exp;
      int en_hi;
      int c;
      en_hi = 0;
      rst4_n = 1'b0;
      #1;
      checks++;
      if (obs4 !== RESET_OBS) begin
         failures++;
         $display("FAIL div4_reset got=%h exp=%h", obs4, RESET_OBS);
      end
      step();
      rst4_n = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         if (enable4) en_hi++;
         step();
         c = k / 4;
         exp = {6'(c), 1'b0, lamps(c), 1'b0};
         checks++;
         if (obs4 !== exp) begin
            failures++;
            $display("FAIL div4_mg k=%0d got=%h exp=%h", k, obs4, exp);
         end
      end
      checks++;
      if (en_hi !== 4) begin
         failures++;
         $display("FAIL div4_enable_cycles got=%0d exp=4", en_hi);
      end
      ped_req4 = 1'b1;
      step();
      ped_req4 = 1'b0;
      for (int i = 0; i < 400 && walk4 !== 1'b1; i++) step();
      checks++;
      if ({walk4, counter4} !== {1'b1, 6'd31}) begin
         failures++;
         $display("FAIL div4_walk got walk=%b cnt=%0d exp walk=1 cnt=31", walk4, counter4);
      end
      step();
      #2;
      rst4_n = 1'b0;
      #1;
      checks++;
      if (obs4 !== RESET_OBS) begin
         failures++;
         $display("FAIL div4_walk_reset got=%h exp=%h", obs4, RESET_OBS);
      end
      step();
      rst4_n = 1'b1;
   endtask

   initial begin
      #3;
      test_reset();
      test_normal();
      test_ped_sg();
      test_ped_ar2();
      test_missed();
      test_spurious();
      test_div4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
